onehot_demux_router: RTL
========================

// Module: onehot_demux_router
// PURPOSE
//   Routes one input stream to one of N output channels. The destination is a one-hot
//   select, so this is the 1-to-N counterpart of the team's N-to-1 one-hot mux.
//   - Valid/ready handshake on the input and on every output; one registered output stage.
//   - Beats with an illegal select (zero-hot or multi-hot) are consumed, dropped and flagged.
//   - Sits between a single producer and N per-lane consumers.
// PARAMETERS
//   N      4  number of output channels (>=2); width of in_sel/out_valid/out_ready
//   W      8  data width in bits
//   ERR_W  8  width of the error counter (used only with ONEHOT_DEMUX_ERRCNT_EN)
// PORTS
//   clk        in   1      single clock; all logic on the rising edge
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      input beat valid
//   in_ready   out  1      input beat accepted when in_valid && in_ready
//   in_data    in   W      input payload
//   in_sel     in   N      one-hot destination; bit i selects channel i
//   out_valid  out  N      per-channel valid; at most one bit set
//   out_ready  in   N      per-channel ready
//   out_data   out  W      shared payload bus; qualified by out_valid
//   err_pulse  out  1      1-cycle pulse after an illegal-select beat is accepted
//   busy       out  1      1 while a beat is held (state FULL)
//   err_cnt    out  ERR_W  saturating illegal-select count (only with ONEHOT_DEMUX_ERRCNT_EN)
// BEHAVIOUR
//   Reset values (rst_n=0 at a clk edge)
//   - state=EMPTY; out_valid=0; out_data=0; err_pulse=0; busy=0; err_cnt=0.
//   - Any held beat is discarded without being delivered.
//   State machine (two states)
//   - EMPTY: in_ready=1.
//       Legal beat accepted: capture in_data and in_sel; go to FULL.
//       Illegal beat accepted: stay in EMPTY.
//   - FULL: out_valid=held_sel; out_data=held_data; busy=1.
//     in_ready = |(held_sel & out_ready). This is a combinational path from out_ready.
//       Drain without a legal accept: go to EMPTY.
//       Drain with a legal accept: reload in the same cycle and stay FULL, giving
//       back-to-back throughput of 1 beat/clk.
//       Drain with an illegal accept: go to EMPTY and drop the input beat.
//   Legality and routing
//   - A select is legal iff in_sel is nonzero and (in_sel & (in_sel-1)) == 0.
//   - Readiness of channels other than held_sel is ignored.
//   Hold rules
//   - While out_valid is set and the channel's ready is 0, out_valid and out_data are
//     stable, and in_ready=0.
//   - In EMPTY, out_data keeps its last value and out_valid=0.
//   Latency
//   - An accepted legal beat appears on out_valid/out_data in the next cycle.
//   - err_pulse is asserted in the cycle after an illegal accept, for exactly 1 cycle per
//     illegal beat. Back-to-back illegal beats keep err_pulse high continuously.
// CONFIGURATION
//   ONEHOT_DEMUX_ERRCNT_EN defined
//   - err_cnt port exists.
//   - err_cnt increments by 1 on each illegal accept.
//   - err_cnt saturates at 2**ERR_W-1; it never wraps.
//   - err_cnt is cleared only by reset.
//   ONEHOT_DEMUX_ERRCNT_EN undefined
//   - No err_cnt port and no counter logic. err_pulse is unchanged.
// TESTING
//   1. Reset: rst_n=0 for 2 clk with in_valid=1, in_sel=0001 -> out_valid=0000, out_data=0,
//      busy=0, err_pulse=0; in_ready=1 on the first cycle after release.
//   2. Route: in_data=A5, in_sel=0100, out_ready=1111 -> next cycle out_valid=0100,
//      out_data=A5; one beat per clk sustained over 16 beats rotating 0001..1000.
//   3. Backpressure: hold beat 3C on ch1 with out_ready[1]=0 for 5 cycles, other readies=1
//      -> out_valid=0010, out_data=3C stable, in_ready=0; ready[1]=1 -> delivered once.
//   4. Illegal select: in_sel=0000 then 0110 -> 2 consecutive err_pulse cycles, no
//      out_valid; with the macro and ERR_W=2, 5 illegal beats -> err_cnt=3 (saturated).
//   5. Simultaneous: FULL on ch0; ready[0]=1 and a new legal beat for ch3 in the same cycle
//      -> ch0 transfer, next cycle out_valid=1000, no bubble.
//   6. Mid-operation reset: beat held on ch2 with out_ready=0, rst_n=0 for 1 clk
//      -> out_valid=0000, busy=0; the beat is never delivered after release.

Source files
------------

// File: rtl/onehot_demux_router.sv
// Purpose : routes one valid/ready input stream to one of N outputs using a one-hot select; drops and flags illegal selects.
// Latency : one registered stage; an accepted legal beat is presented on the cycle after acceptance. err_pulse follows an illegal accept by one cycle.
// Backpr. : in_ready follows the held channel's out_ready combinationally, so a drain and a reload can share one cycle. Optional err_cnt under ONEHOT_DEMUX_ERRCNT_EN.
module onehot_demux_router #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [N-1:0]     in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [W-1:0]     out_data,
  output logic             err_pulse,
  output logic             busy
`ifdef ONEHOT_DEMUX_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [N-1:0] SEL_ONE = N'(1);

  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [W-1:0]   data_q, data_d;
  logic           err_pulse_q, err_pulse_d;

  logic           sel_legal;
  logic           held_rdy;
  logic           accept;
  logic           load;

  // A select is legal only when exactly one bit is set.
  always_comb begin
    sel_legal = (in_sel != '0) && ((in_sel & (in_sel - SEL_ONE)) == '0);
  end

  // Handshake decode and next-state for the single holding register.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    data_d      = data_q;
    in_ready    = 1'b0;
    held_rdy    = |(sel_q & out_ready);
    accept      = 1'b0;
    load        = 1'b0;
    err_pulse_d = 1'b0;

    // Only the held channel's ready matters; other lanes are ignored.
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL:  in_ready = held_rdy;
      default:  in_ready = 1'b0;
    endcase

    accept      = in_valid && in_ready;
    load        = accept && sel_legal;
    err_pulse_d = accept && !sel_legal;

    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // Draining frees the slot; a legal beat in the same cycle refills it.
        if (held_rdy) begin
          state_d = load ? ST_FULL : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Payload only changes on a legal load, so out_data holds its last value when idle.
    if (load) begin
      sel_d  = in_sel;
      data_d = in_data;
    end
  end

  // Holding register and error pulse; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      sel_q       <= '0;
      data_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Output drive: valid is gated by state, data bus is shared across lanes.
  always_comb begin
    out_valid = (state_q == ST_FULL) ? sel_q : '0;
    out_data  = data_q;
    busy      = (state_q == ST_FULL);
    err_pulse = err_pulse_q;
  end

`ifdef ONEHOT_DEMUX_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of illegal-select beats; cleared only by reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pulse_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Counter output.
  always_comb begin
    err_cnt = err_cnt_q;
  end
`endif

endmodule
